// File: rtl/fifo_async_pkg.sv
// Shared helpers for both pointer domains of the asynchronous FIFO:
// depth derivation, binary-to-Gray conversion and the full-compare mask.
package fifo_async_pkg;

    typedef logic [31:0] ptr_word_t;

    function automatic int unsigned depth_of(input int unsigned ptr_width);
        return 32'd1 << (ptr_width - 1);
    endfunction

    function automatic ptr_word_t bin2gray(input ptr_word_t bin);
        return (bin >> 1) ^ bin;
    endfunction

    // {1'b1, zeros}: the pointer difference that means exactly one lap ahead
    function automatic ptr_word_t full_mask(input int unsigned ptr_width);
        return ptr_word_t'(1) << (ptr_width - 1);
    endfunction

endpackage

// File: rtl/fifo_async_write_ptr_if.sv
// Write-side pointer/flag bundle. almost_full_out exists only when
// FIFO_WPTR_AFULL_EN is defined.
interface fifo_async_write_ptr_if #(
    parameter int PTR_WIDTH = 4
);
    logic                 write_in;
    logic                 ovf_clr_in;
    logic [PTR_WIDTH-1:0] rptr_g_sync_in;
    logic [PTR_WIDTH-1:0] wptr_b_out;
    logic [PTR_WIDTH-1:0] wptr_g_out;
    logic                 full_out;
    logic [PTR_WIDTH-1:0] level_out;
    logic                 overflow_out;
`ifdef FIFO_WPTR_AFULL_EN
    logic                 almost_full_out;
`endif

    modport master (
        output write_in, ovf_clr_in, rptr_g_sync_in,
        input  wptr_b_out, wptr_g_out, full_out, level_out, overflow_out
`ifdef FIFO_WPTR_AFULL_EN
        , input almost_full_out
`endif
    );

    modport slave (
        input  write_in, ovf_clr_in, rptr_g_sync_in,
        output wptr_b_out, wptr_g_out, full_out, level_out, overflow_out
`ifdef FIFO_WPTR_AFULL_EN
        , output almost_full_out
`endif
    );
endinterface

// File: rtl/gray2bin.sv
// Gray-to-binary converter: each binary bit is the XOR of all Gray bits at or above it.
module gray2bin #(
    parameter int N = 4
) (
    input  logic [N-1:0] i_gray,
    output logic [N-1:0] o_bin
);
    for (genvar gi = 0; gi < N; gi++) begin : g_bit
        assign o_bin[gi] = ^i_gray[N-1:gi];
    end
endmodule

// File: rtl/fifo_async_write_ptr.sv
// Write-domain pointer, full, level and sticky overflow for the async FIFO.
// Optional almost-full output is enabled by defining FIFO_WPTR_AFULL_EN.
module fifo_async_write_ptr
    import fifo_async_pkg::*;
#(
    parameter int PTR_WIDTH    = 4,
    parameter int AFULL_THRESH = 6
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    fifo_async_write_ptr_if.slave  wp
);
    localparam int unsigned          DEPTH     = depth_of(PTR_WIDTH);
    localparam logic [PTR_WIDTH-1:0] FULL_MASK = PTR_WIDTH'(full_mask(PTR_WIDTH));

    if (AFULL_THRESH < 1 || AFULL_THRESH > int'(DEPTH)) begin : g_thresh_range
        $error("AFULL_THRESH must lie in 1..DEPTH");
    end

    logic [PTR_WIDTH-1:0] r_wptr_b;
    logic [PTR_WIDTH-1:0] r_wptr_g;
    logic [PTR_WIDTH-1:0] r_level;
    logic                 r_full;
    logic                 r_overflow;

    logic                 w_accept;
    logic [PTR_WIDTH-1:0] w_rptr_b_sync;
    logic [PTR_WIDTH-1:0] w_wptr_b_next;
    logic [PTR_WIDTH-1:0] w_wptr_g_next;
    logic [PTR_WIDTH-1:0] w_level_next;
    logic                 w_full_next;
    logic                 w_overflow_next;

    gray2bin #(.N(PTR_WIDTH)) u_rptr_g2b (
        .i_gray (wp.rptr_g_sync_in),
        .o_bin  (w_rptr_b_sync)
    );

    assign w_accept        = wp.write_in & ~r_full;
    assign w_wptr_b_next   = r_wptr_b + PTR_WIDTH'(w_accept);
    assign w_wptr_g_next   = PTR_WIDTH'(bin2gray(ptr_word_t'(w_wptr_b_next)));
    assign w_level_next    = w_wptr_b_next - w_rptr_b_sync;
    assign w_full_next     = (w_wptr_b_next ^ w_rptr_b_sync) == FULL_MASK;
    // A fresh rejected write beats a simultaneous clear
    assign w_overflow_next = (wp.write_in & r_full) | (r_overflow & ~wp.ovf_clr_in);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_wptr_b   <= '0;
            r_wptr_g   <= '0;
            r_level    <= '0;
            r_full     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_wptr_b   <= w_wptr_b_next;
            r_wptr_g   <= w_wptr_g_next;
            r_level    <= w_level_next;
            r_full     <= w_full_next;
            r_overflow <= w_overflow_next;
        end
    end

    assign wp.wptr_b_out   = r_wptr_b;
    assign wp.wptr_g_out   = r_wptr_g;
    assign wp.level_out    = r_level;
    assign wp.full_out     = r_full;
    assign wp.overflow_out = r_overflow;

`ifdef FIFO_WPTR_AFULL_EN
    logic r_almost_full;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_almost_full <= 1'b0;
        end else begin
            r_almost_full <= int'(w_level_next) >= AFULL_THRESH;
        end
    end

    assign wp.almost_full_out = r_almost_full;
`endif

endmodule

// File: tb/tb_fifo_async_write_ptr.sv
// Directed plus randomized bench for fifo_async_write_ptr (PTR_WIDTH=4, DEPTH=8).
module tb_fifo_async_write_ptr;
    localparam int PW    = 4;
    localparam int DEPTH = 8;
    localparam int AFT   = 6;

    logic clk_in = 1'b0;
    logic rst_in;

    always #5 clk_in = ~clk_in;

    fifo_async_write_ptr_if #(.PTR_WIDTH(PW)) bus ();

    fifo_async_write_ptr #(.PTR_WIDTH(PW), .AFULL_THRESH(AFT)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .wp     (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: total accepted writes and total reads as plain counts
    int m_w;
    int m_r;
    bit m_full;
    bit m_ovf;

    function automatic logic [PW-1:0] gray_of(input int count);
        int p;
        p = count % 16;
        return PW'(p ^ (p >> 1));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_model(input string tag);
        int lvl;
        lvl = m_w - m_r;
        chk({tag, ".wptr_b"}, 32'(bus.wptr_b_out), 32'(m_w % 16));
        chk({tag, ".wptr_g"}, 32'(bus.wptr_g_out), 32'(gray_of(m_w)));
        chk({tag, ".level"}, 32'(bus.level_out), 32'(lvl));
        chk({tag, ".full"}, 32'(bus.full_out), 32'(m_full));
        chk({tag, ".ovf"}, 32'(bus.overflow_out), 32'(m_ovf));
`ifdef FIFO_WPTR_AFULL_EN
        chk({tag, ".afull"}, 32'(bus.almost_full_out), 32'(lvl >= AFT));
`endif
        $display("%s: wr=%0b clr=%0b rptr_g=%0h -> wptr_b=%0d level=%0d full=%0b ovf=%0b",
                 tag, bus.write_in, bus.ovf_clr_in, bus.rptr_g_sync_in,
                 bus.wptr_b_out, bus.level_out, bus.full_out, bus.overflow_out);
    endtask

    task automatic cycle(input string tag, input bit wr, input bit clr, input int rc);
        bit acc;
        bit ovf_new;
        rst_in             = 1'b0;
        bus.write_in       = wr;
        bus.ovf_clr_in     = clr;
        bus.rptr_g_sync_in = gray_of(rc);
        acc     = wr && !m_full;
        ovf_new = (wr && m_full) || (m_ovf && !clr);
        m_w     = m_w + int'(acc);
        m_r     = rc;
        m_full  = (m_w - m_r) == DEPTH;
        m_ovf   = ovf_new;
        @(posedge clk_in);
        #1;
        check_model(tag);
    endtask

    task automatic do_reset(input string tag, input int cycles);
        rst_in             = 1'b1;
        bus.write_in       = 1'b1;
        bus.ovf_clr_in     = 1'b0;
        bus.rptr_g_sync_in = '0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk_in);
            #1;
            chk({tag, ".wptr_b"}, 32'(bus.wptr_b_out), 32'd0);
            chk({tag, ".wptr_g"}, 32'(bus.wptr_g_out), 32'd0);
            chk({tag, ".full"}, 32'(bus.full_out), 32'd0);
            chk({tag, ".level"}, 32'(bus.level_out), 32'd0);
            chk({tag, ".ovf"}, 32'(bus.overflow_out), 32'd0);
`ifdef FIFO_WPTR_AFULL_EN
            chk({tag, ".afull"}, 32'(bus.almost_full_out), 32'd0);
`endif
            $display("%s: cycle %0d wptr_b=%0d full=%0b", tag, i, bus.wptr_b_out, bus.full_out);
        end
        m_w = 0; m_r = 0; m_full = 1'b0; m_ovf = 1'b0;
    endtask

    initial begin
        int rc;
        bit wr;
        bit clr;

        // Reset held with write requested: nothing may move
        do_reset("reset", 2);

        // Fill to full, then one rejected write
        for (int i = 1; i <= 9; i++) begin
            cycle($sformatf("fill%0d", i), 1'b1, 1'b0, 0);
            if (i == 8) begin
                chk("fill8.ptr_is_8", 32'(bus.wptr_b_out), 32'd8);
                chk("fill8.gray_1100", 32'(bus.wptr_g_out), 32'b1100);
                chk("fill8.full", 32'(bus.full_out), 32'd1);
                chk("fill8.level8", 32'(bus.level_out), 32'd8);
            end
        end
        chk("fill9.ptr_held", 32'(bus.wptr_b_out), 32'd8);
        chk("fill9.ovf_set", 32'(bus.overflow_out), 32'd1);

        // Set and clear together while full: set wins; then clear alone
        cycle("race_set", 1'b1, 1'b1, 0);
        chk("race.ovf_kept", 32'(bus.overflow_out), 32'd1);
        cycle("race_clr", 1'b0, 1'b1, 0);
        chk("race.ovf_cleared", 32'(bus.overflow_out), 32'd0);

        // Release: read pointer advances to 3
        cycle("release", 1'b0, 1'b0, 3);
        chk("release.full0", 32'(bus.full_out), 32'd0);
        chk("release.level5", 32'(bus.level_out), 32'd5);

        // Advance write pointer to 15 with read at 8, then read at 10, then wrap
        for (int i = 0; i < 7; i++) cycle($sformatf("to15_%0d", i), 1'b1, 1'b0, 8);
        chk("pre_wrap.ptr15", 32'(bus.wptr_b_out), 32'd15);
        chk("pre_wrap.gray1000", 32'(bus.wptr_g_out), 32'b1000);
        cycle("rd10", 1'b0, 1'b0, 10);
        cycle("wrap", 1'b1, 1'b0, 10);
        chk("wrap.ptr0", 32'(bus.wptr_b_out), 32'd0);
        chk("wrap.gray0", 32'(bus.wptr_g_out), 32'd0);
        chk("wrap.level6", 32'(bus.level_out), 32'd6);
        chk("wrap.full0", 32'(bus.full_out), 32'd0);

        // Randomized traffic; the read count never overtakes accepted writes
        for (int i = 0; i < 400; i++) begin
            wr  = ($urandom % 4) != 0;
            clr = ($urandom % 8) == 0;
            rc  = m_r + int'($urandom_range(0, 2));
            if (rc > m_w) rc = m_w;
            cycle($sformatf("rnd%0d", i), wr, clr, rc);
        end

        // Reset mid-operation with write asserted
        do_reset("midreset", 1);

`ifdef FIFO_WPTR_AFULL_EN
        for (int i = 1; i <= 6; i++) begin
            cycle($sformatf("afill%0d", i), 1'b1, 1'b0, 0);
            if (i == 5) chk("afull.off_at5", 32'(bus.almost_full_out), 32'd0);
        end
        chk("afull.on_at6", 32'(bus.almost_full_out), 32'd1);
        cycle("afull_drop", 1'b0, 1'b0, 1);
        chk("afull.level5", 32'(bus.level_out), 32'd5);
        chk("afull.dropped", 32'(bus.almost_full_out), 32'd0);
`else
        cycle("post_reset_wr", 1'b1, 1'b0, 0);
        chk("post_reset.ptr1", 32'(bus.wptr_b_out), 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
